aes_key_expand: RTL



---
 rtl/aes_key_expand.sv | 138 +++++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: writes one 32-bit word per clock into a 44-word image, 40 clocks from accepted start to valid.
// No backpressure: start is taken only in IDLE/DONE and ignored while expanding; w is held stable in DONE.
module aes_key_expand #(
   parameter int NR = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [127:0]  key,
   output logic [1407:0] w,
   output logic          busy,
   output logic          valid
);

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   generate
      if (NR != 10) begin : g_nr_check
         $error("aes_key_expand supports only NR = 10 (AES-128)");
      end
   endgenerate

   state_t          r_state;
   logic [5:0]      r_cnt;
   logic [3:0]      r_rcon_idx;
   logic [1407:0]   r_w;
   logic            r_busy;
   logic            r_valid;

   logic [31:0]     w_word [64];
   logic [31:0]     w_prev;
   logic [31:0]     w_back4;
   logic [31:0]     w_rot;
   logic [31:0]     w_sub;
   logic [31:0]     w_temp;
   logic [31:0]     w_next;
   logic [7:0]      w_rcon;

   // Word view of the schedule, padded to 64 so any 6-bit counter value indexes safely.
   genvar g;
   generate
      for (g = 0; g < 64; g++) begin : g_words
         if (g < 44) begin : g_live
            assign w_word[g] = r_w[1407-32*g -: 32];
         end else begin : g_pad
            assign w_word[g] = 32'h0;
         end
      end
   endgenerate

   assign w_prev  = w_word[r_cnt - 6'd1];
   assign w_back4 = w_word[r_cnt - 6'd4];
   assign w_rot   = {w_prev[23:0], w_prev[31:24]};
   assign w_sub   = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]};

   always_comb begin
      w_rcon = 8'h00;
      case (r_rcon_idx)
         4'd0:    w_rcon = 8'h01;
         4'd1:    w_rcon = 8'h02;
         4'd2:    w_rcon = 8'h04;
         4'd3:    w_rcon = 8'h08;
         4'd4:    w_rcon = 8'h10;
         4'd5:    w_rcon = 8'h20;
         4'd6:    w_rcon = 8'h40;
         4'd7:    w_rcon = 8'h80;
         4'd8:    w_rcon = 8'h1b;
         4'd9:    w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   assign w_temp = (r_cnt[1:0] == 2'b00) ? (w_sub ^ {w_rcon, 24'h0}) : w_prev;
   assign w_next = w_back4 ^ w_temp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= 6'd0;
         r_rcon_idx <= 4'd0;
         r_w        <= '0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_w        <= {key, 1280'h0};
                  r_cnt      <= 6'd4;
                  r_rcon_idx <= 4'd0;
                  r_busy     <= 1'b1;
                  r_valid    <= 1'b0;
                  r_state    <= EXPAND;
               end
            end
            EXPAND: begin
               for (int j = 4; j < 44; j++) begin
                  if (r_cnt == 6'(j)) r_w[1407-32*j -: 32] <= w_next;
               end
               // Index saturates at 9: the last rcon use (word 40) reads entry 9.
               if (r_cnt[1:0] == 2'b00 && r_rcon_idx != 4'd9) r_rcon_idx <= r_rcon_idx + 4'd1;
               if (r_cnt == 6'd43) begin
                  r_busy  <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w     = r_w;
   assign busy  = r_busy;
   assign valid = r_valid;

endmodule
